// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths and types for the D-MEM port arbiter.
package dmem_port_arbiter_pkg;
    localparam int DBITS        = 32;
    localparam int DMEMADDRBITS = 16;
    localparam int DMEMWORDBITS = 2;
    localparam int DMEMIDXBITS  = DMEMADDRBITS - DMEMWORDBITS;
    localparam int STARVE_CNT_W = 4;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_owner_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the P and X requester ports, the RAM side and arbiter status.
interface dmem_port_arbiter_if #(
    parameter int DBITS        = dmem_port_arbiter_pkg::DBITS,
    parameter int DMEMADDRBITS = dmem_port_arbiter_pkg::DMEMADDRBITS,
    parameter int DMEMWORDBITS = dmem_port_arbiter_pkg::DMEMWORDBITS
);
    logic                                 p_req, p_we, p_gnt, p_rvalid;
    logic [DBITS-1:0]                     p_addr, p_wdata, p_rdata;
    logic                                 x_req, x_we, x_gnt, x_rvalid;
    logic [DBITS-1:0]                     x_addr, x_wdata, x_rdata;
    logic                                 mem_en, mem_we;
    logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr;
    logic [DBITS-1:0]                     mem_wdata, mem_rdata;
    logic                                 x_starved;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        input  x_req, x_we, x_addr, x_wdata,
        input  mem_rdata,
        output p_gnt, p_rvalid, p_rdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output x_starved
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        output x_req, x_we, x_addr, x_wdata,
        output mem_rdata,
        input  p_gnt, p_rvalid, p_rdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  x_starved
    );
endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Saturating refusal counter; at_limit_o is decoded straight from the register.
module dmem_port_arbiter_starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != LIM)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q == LIM);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port D-MEM: P has priority, X is
// guaranteed a grant after STARVE_LIMIT consecutive refusals.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DBITS        = dmem_port_arbiter_pkg::DBITS,
    parameter int DMEMADDRBITS = dmem_port_arbiter_pkg::DMEMADDRBITS,
    parameter int DMEMWORDBITS = dmem_port_arbiter_pkg::DMEMWORDBITS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);
    localparam logic OWN_P = 1'b0;
    localparam logic OWN_X = 1'b1;

    logic      at_limit, x_win, p_gnt, x_gnt;
    rd_owner_t rd_owner_q, rd_owner_d;

    dmem_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_CNT_W)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (bus.x_req && !x_gnt),
        .clr_i      (x_gnt || !bus.x_req),
        .at_limit_o (at_limit)
    );

    assign x_win = bus.x_req && at_limit;
    assign p_gnt = bus.p_req && !x_win;
    assign x_gnt = bus.x_req && (x_win || !bus.p_req);

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (x_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.x_we;
            bus.mem_addr  = bus.x_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            bus.mem_wdata = bus.x_wdata;
        end else if (p_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.p_we;
            bus.mem_addr  = bus.p_addr[DMEMADDRBITS-1:DMEMWORDBITS];
            bus.mem_wdata = bus.p_wdata;
        end
    end

    always_comb begin
        rd_owner_d.valid = (p_gnt && !bus.p_we) || (x_gnt && !bus.x_we);
        rd_owner_d.owner = x_gnt ? OWN_X : OWN_P;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_owner_q <= '0;
        else       rd_owner_q <= rd_owner_d;
    end

    // A read granted just before reset has its return masked while reset is high.
    assign bus.p_rvalid  = rd_owner_q.valid && (rd_owner_q.owner == OWN_P) && !reset;
    assign bus.x_rvalid  = rd_owner_q.valid && (rd_owner_q.owner == OWN_X) && !reset;
    assign bus.p_rdata   = bus.mem_rdata;
    assign bus.x_rdata   = bus.mem_rdata;
    assign bus.p_gnt     = p_gnt;
    assign bus.x_gnt     = x_gnt;
    assign bus.x_starved = at_limit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.p_addr[DBITS-1:DMEMADDRBITS], bus.p_addr[DMEMWORDBITS-1:0],
                                bus.x_addr[DBITS-1:DMEMADDRBITS], bus.x_addr[DMEMWORDBITS-1:0]};
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural RAM, grant model and read-return scoreboard.
module tb_dmem_port_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [256];
    logic [31:0] exp_mem [256];
    logic [31:0] rdata_q;
    assign bus.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            rdata_q <= ram[bus.mem_addr[7:0]];
        end
    end

    function automatic logic [31:0] init_val(int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | (i * 3));
    endfunction

    typedef struct {
        logic        own;
        logic [31:0] data;
    } rd_t;

    rd_t sbq[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  ecnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                        input logic xr, input logic xw, input logic [31:0] xa, input logic [31:0] xd);
        logic        eg_p, eg_x, e_we;
        logic [31:0] e_addr, e_wd;
        rd_t         e;
        reset = rst;
        bus.p_req = pr; bus.p_we = pw; bus.p_addr = pa; bus.p_wdata = pd;
        bus.x_req = xr; bus.x_we = xw; bus.x_addr = xa; bus.x_wdata = xd;
        eg_x = xr && ((ecnt == LIM) || !pr);
        eg_p = pr && !eg_x;
        e_we   = eg_x ? xw : (eg_p ? pw : 1'b0);
        e_addr = eg_x ? {18'b0, xa[15:2]} : (eg_p ? {18'b0, pa[15:2]} : 32'h0);
        e_wd   = eg_x ? xd : (eg_p ? pd : 32'h0);
        @(negedge clk);
        chk("p_gnt", bus.p_gnt, eg_p);
        chk("x_gnt", bus.x_gnt, eg_x);
        chk("mem_en", bus.mem_en, eg_p | eg_x);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", {18'b0, bus.mem_addr}, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("x_starved", bus.x_starved, ecnt == LIM);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("p_rvalid", bus.p_rvalid, !rst && !e.own);
            chk("x_rvalid", bus.x_rvalid, !rst && e.own);
            if (!rst) chk("rdata", e.own ? bus.x_rdata : bus.p_rdata, e.data);
        end else begin
            chk("p_rvalid_idle", bus.p_rvalid, 1'b0);
            chk("x_rvalid_idle", bus.x_rvalid, 1'b0);
        end
        if (!rst && (eg_p || eg_x) && !e_we)
            sbq.push_back('{own: eg_x, data: exp_mem[e_addr[7:0]]});
        if ((eg_p || eg_x) && e_we)
            exp_mem[e_addr[7:0]] = e_wd;
        @(posedge clk);
        if (rst)              ecnt = 0;
        else if (xr && !eg_x) ecnt = (ecnt == LIM) ? LIM : ecnt + 1;
        else                  ecnt = 0;
        #1;
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     <= init_val(i);
            exp_mem[i]  = init_val(i);
        end
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.x_req = 0; bus.x_we = 0; bus.x_addr = '0; bus.x_wdata = '0;
        reset = 1'b1;
        @(posedge clk); #1;

        // reset and quiet bus
        idle(1); idle(1); idle(0); idle(0);

        // P load of word 4
        step(0, 1, 0, 32'h0000_0010, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(0);

        // X store then P load of the same word
        step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0000_0020, 32'h1234_5678);
        step(0, 1, 0, 32'h0000_0020, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(0);

        // upper address bits alias
        step(0, 1, 0, 32'h0001_0014, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(0);

        // continuous contention: X wins every fifth cycle
        repeat (12) step(0, 1, 0, 32'h0000_0008, 32'h0, 1, 0, 32'h0000_000C, 32'h0);
        idle(0);

        // read return killed by reset, then X read works
        step(0, 1, 0, 32'h0000_0010, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(1);
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0000_0020, 32'h0);
        idle(0);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            step(($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3)),
                 $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (32'($urandom_range(0, 255)) << 2),
                 $urandom);
        end
        idle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
